// File: rtl/inversor_bank.sv
// inversor_bank: registered per-channel polarity bank with pass, invert,
// periodic-toggle and force modes. The polarity mask is loaded serially into a
// shadow register and copied to the active mask on commit.
// Build option: define INVERSOR_BANK_SYNC_EN to put a 2-flop synchroniser on
// every input channel. This adds 2 cycles of in-to-out latency.
module inversor_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  input  logic             cfg_commit,
  output logic [WIDTH-1:0] out,
  output logic             phase,
  output logic [WIDTH-1:0] mask_q
);

  typedef enum logic [1:0] {
    ModePass   = 2'b00,
    ModeInvert = 2'b01,
    ModeToggle = 2'b10,
    ModeForce  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_d;
  logic [WIDTH-1:0] out_d;

  assign mode_sel = mode_e'(mode);

`ifdef INVERSOR_BANK_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for asynchronous pad inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign x = sync2_q;
`else
  assign x = in;
`endif

  // Serial shift into the shadow mask; the commit sees this edge's shift
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_valid) begin
      shadow_d = {shadow_q[WIDTH-2:0], cfg_bit};
    end
  end

  // Toggle divider: counts only in toggle mode, held cleared otherwise
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (mode_sel == ModeToggle) begin
      // >= so that lowering div below cnt wraps at once instead of running away
      if (cnt_q >= div) begin
        cnt_d   = '0;
        phase_d = ~phase;
      end else begin
        cnt_d   = cnt_q + DIV_W'(1);
        phase_d = phase;
      end
    end
  end

  // Output function; toggle mode uses the phase from before this edge's flip
  always_comb begin
    out_d = x;
    unique case (mode_sel)
      ModePass:   out_d = x;
      ModeInvert: out_d = x ^ mask_q;
      ModeToggle: out_d = x ^ (mask_q & {WIDTH{phase}});
      ModeForce:  out_d = mask_q;
    endcase
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      phase    <= 1'b0;
      out      <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (cfg_commit) begin
        mask_q <= shadow_d;
      end
      cnt_q <= cnt_d;
      phase <= phase_d;
      out   <= out_d;
    end
  end

endmodule

// File: tb/tb_inversor_bank.sv
// Self-checking bench for inversor_bank (WIDTH=8, DIV_W=16): a vector table
// for the steady-state output function plus directed multi-cycle sequences.
module tb_inversor_bank;

`ifdef INVERSOR_BANK_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in;
  logic [1:0]  mode;
  logic [15:0] div;
  logic        cfg_valid, cfg_bit, cfg_commit;
  logic [7:0]  out;
  logic        phase;
  logic [7:0]  mask_q;

  int checks = 0;
  int errors = 0;

  inversor_bank #(.WIDTH(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .mode       (mode),
    .div        (div),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_commit (cfg_commit),
    .out        (out),
    .phase      (phase),
    .mask_q     (mask_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Shift 8 bits MSB first, optionally committing together with the last bit
  task automatic shift8(input logic [7:0] bits, input logic commit_last);
    for (int i = 7; i >= 0; i--) begin
      cfg_valid  = 1'b1;
      cfg_bit    = bits[i];
      cfg_commit = commit_last && (i == 0);
      tick();
    end
    cfg_valid  = 1'b0;
    cfg_bit    = 1'b0;
    cfg_commit = 1'b0;
  endtask

  vec_t vecs [8];
  logic ph_exp [12];
  logic [7:0] out_exp [12];

  initial begin
    // Expected results with mask_q = 8'hF0 and div held large
    vecs[0] = '{2'b00, 8'h3C, 8'h3C};
    vecs[1] = '{2'b01, 8'h3C, 8'hCC};
    vecs[2] = '{2'b01, 8'hFF, 8'h0F};
    vecs[3] = '{2'b11, 8'h12, 8'hF0};
    vecs[4] = '{2'b00, 8'h81, 8'h81};
    vecs[5] = '{2'b01, 8'h5A, 8'hAA};
    vecs[6] = '{2'b11, 8'h00, 8'hF0};
    vecs[7] = '{2'b10, 8'h3C, 8'h3C};
    // mask 0F, div=2: phase and out after each of the first 12 toggle-mode edges
    ph_exp  = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    out_exp = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F,
                8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F};

    rst = 1'b1; in = 8'hA5; mode = 2'b01; div = 16'd0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_commit = 1'b0;

    // Reset
    tick(); tick();
    check("reset_out", out, 8'h00);
    check("reset_mask", mask_q, 8'h00);
    check("reset_phase", phase, 1'b0);
    rst = 1'b0;
    repeat (Lat) tick();
    check("post_reset_out", out, 8'hA5);

    // Load and invert
    in = 8'h00;
    shift8(8'hF0, 1'b0);
    check("mask_before_commit", mask_q, 8'h00);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("commit_mask", mask_q, 8'hF0);
    check("commit_out_old_mask", out, 8'h00);
    tick();
    check("commit_out", out, 8'hF0);

    // Output function table
    div = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      in   = vecs[i].din;
      repeat (Lat) tick();
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Simultaneous shift and commit
    mode = 2'b00; in = 8'h00;
    shift8(8'h01, 1'b0);
    check("shadow_not_committed", mask_q, 8'hF0);
    cfg_valid = 1'b1; cfg_bit = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_commit = 1'b0;
    check("simul_commit", mask_q, 8'h03);

    // Toggle, div=2
    shift8(8'h0F, 1'b1);
    check("mask_0f", mask_q, 8'h0F);
    repeat (Lat) tick();
    mode = 2'b10; div = 16'd2; in = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("tog_phase%0d", k), phase, ph_exp[k]);
      check($sformatf("tog_out%0d", k), out, out_exp[k]);
    end

    // div=0 toggles every cycle
    mode = 2'b00; tick();
    check("leave_toggle_phase", phase, 1'b0);
    mode = 2'b10; div = 16'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("div0_phase%0d", k), phase, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("div0_out%0d", k), out, (k % 2 == 0) ? 8'h00 : 8'h0F);
    end

    // Lowering div below cnt wraps on the next edge
    mode = 2'b00; tick();
    mode = 2'b10; div = 16'd10;
    repeat (5) tick();
    check("div10_phase", phase, 1'b0);
    div = 16'd1;
    tick();
    check("div_drop_wrap", phase, 1'b1);
    check("div_drop_out", out, 8'h00);
    tick();
    check("div1_hold", phase, 1'b1);
    check("div1_out", out, 8'h0F);
    tick();
    check("div1_flip", phase, 1'b0);
    tick(); tick();
    check("div1_flip2", phase, 1'b1);

    // Switch to pass clears phase and passes in
    mode = 2'b00; in = 8'hC3;
    repeat (Lat) tick();
    check("pass_phase", phase, 1'b0);
    check("pass_out", out, 8'hC3);

    // Force
    shift8(8'h5A, 1'b1);
    mode = 2'b11; in = 8'h00;
    tick();
    check("force_out0", out, 8'h5A);
    in = 8'hFF;
    repeat (Lat) tick();
    check("force_out1", out, 8'h5A);

    // Reset mid-shift discards the partial shadow
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_mask", mask_q, 8'h00);
    check("rst_mid_out", out, 8'h00);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("rst_shadow_cleared", mask_q, 8'h00);

    // Reset mid-toggle restarts the divider
    mode = 2'b10; div = 16'd3;
    repeat (5) tick();
    check("pre_rst_phase", phase, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_toggle_phase", phase, 1'b0);
    repeat (3) tick();
    check("restart_no_flip", phase, 1'b0);
    tick();
    check("restart_flip", phase, 1'b1);

    // Input step latency
    mode = 2'b00; in = 8'h00;
    repeat (3) tick();
    in = 8'hFF;
`ifdef INVERSOR_BANK_SYNC_EN
    tick();
    check("sync_t1", out, 8'h00);
    tick();
    check("sync_t2", out, 8'h00);
    tick();
    check("sync_t3", out, 8'hFF);
`else
    tick();
    check("step_t1", out, 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inversor_bank.md
# inversor_bank

Parametrised, registered successor to the single-bit inverter. It applies a per-channel polarity mask across a WIDTH-bit bus, and it supports pass, invert, periodic-toggle and force modes. The mask is loaded through a serial shift/commit interface, so that a few Tiny Tapeout pins can configure a wide bank. The block sits between the project's input pins and the downstream logic, or drives output pins directly.

## Interface
- WIDTH, 8: number of channels; legal range 2..32.
- DIV_W, 16: width of the toggle divider and its counter.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  data channels.
- mode  input  2  operating mode: 00 pass, 01 invert, 10 toggle, 11 force.
- div  input  DIV_W  toggle half-period minus one, in clk cycles.
- cfg_valid  input  1  shift cfg_bit into the shadow mask this cycle.
- cfg_bit  input  1  serial mask bit.
- cfg_commit  input  1  copy the shadow mask into the active mask.
- out  output  WIDTH  registered result.
- phase  output  1  current toggle phase. It is 0 outside mode 10.
- mask_q  output  WIDTH  active mask, for readback.

## Operation
- **Shadow mask.**
  - The shadow mask is a WIDTH-bit register.
  - When cfg_valid=1: shadow <= {shadow[WIDTH-2:0], cfg_bit}.
  - The first bit shifted in ends at the MSB after WIDTH shifts.
- **Active mask.**
  - When cfg_commit=1: mask_q <= the value the shadow holds after this edge's shift.
  - So if cfg_valid and cfg_commit are asserted in the same cycle, the bit shifted in that cycle is included in the commit.
  - The shadow is not cleared by a commit.
- **Output function**, evaluated on the edge and registered into out (x is `in`, or the synchronised `in` when the sync feature is on):
  - Mode 00: out <= x.
  - Mode 01: out <= x ^ mask_q.
  - Mode 10: out <= x ^ (mask_q & {WIDTH{phase}}).
  - Mode 11: out <= mask_q.
- **Divider** (active in mode 10 only):
  - cnt is DIV_W bits.
  - If cnt >= div: cnt <= 0 and phase flips. Otherwise cnt <= cnt+1.
  - div=0 flips phase every cycle.
  - Lowering div below the current cnt causes a wrap on the next edge. The comparison is >=, so the counter never runs away.
- **Leaving mode 10.**
  - In any mode other than 10: cnt <= 0 and phase <= 0.
  - Re-entering mode 10 starts from phase 0, with the first flip after div+1 cycles.
- **Mode changes.** A mode change takes effect on the next edge; there are no pipeline bubbles.

## Timing
- **Reset values.** With rst=1 at an edge: out=0, mask_q=0, shadow=0, cnt=0, phase=0. rst has priority over every other input.
- **Reset mid-operation.**
  - Reset mid-shift discards the partial shadow.
  - Reset mid-toggle restarts the divider.
- **Data latency.** in to out is 1 cycle (3 cycles with the sync feature).
- **Commit latency.** A commit is visible on mask_q 1 cycle after cfg_commit is sampled, and on out 1 cycle later.
- **Toggle period.** In steady mode 10, phase is a square wave with period 2*(div+1) cycles.
- **Phase and out alignment.** out uses the phase value before the flip on the same edge, so out lags phase by 1 cycle.
- **Combinational paths.** None from input to output.

## Configuration
- Macro: INVERSOR_BANK_SYNC_EN.
- **Defined:**
  - `in` passes through a 2-flop synchroniser per channel before the output function.
  - Synchroniser reset value is 0.
  - in-to-out latency becomes 3 cycles.
  - Intended for asynchronous pad inputs.
- **Undefined:**
  - `in` is used directly.
  - Latency is 1 cycle.
  - The caller guarantees `in` is synchronous to clk.
- Configuration, divider and mode timing are identical in both builds.

## Test plan
- **Reset:** drive in=8'hA5, mode=01, rst=1 for 2 cycles, then release → out=0, mask_q=0, phase=0; next cycle out=8'hA5 (mask is 0).
- **Load and invert:** shift 8 bits 1,1,1,1,0,0,0,0 then cfg_commit, with mode=01 and in=8'h00 → mask_q=8'hF0 the cycle after commit; out=8'hF0 one cycle later.
- **Simultaneous shift and commit:** shadow=8'h01, then cfg_valid=1, cfg_bit=1 and cfg_commit=1 in the same cycle → mask_q=8'h03.
- **Toggle:** mask_q=8'h0F, mode=10, div=2, in=8'h00 → phase flips every 3 cycles; out alternates 8'h00 and 8'h0F with a 6-cycle period, lagging phase by 1 cycle.
- **Divider boundaries:**
  - div=0 → out toggles every cycle.
  - Change div from 10 to 1 while cnt=5 → wrap on the next edge.
  - Switch mode to 00 → phase=0 on the next cycle and out equals in.
- **Force and sync build:**
  - mode=11 with mask_q=8'h5A → out=8'h5A regardless of in.
  - With INVERSOR_BANK_SYNC_EN, mode=00 and an in step at cycle t → out changes at t+3.
